// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared widths, state encoding and packing helper for the
//            int_to_fp / fp_to_int pair.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W       = 4;
    localparam int FRAC_W      = 8;
    localparam int INT_W       = 8;
    localparam int FLOAT_W     = 1 + EXP_W + FRAC_W;
    localparam int CNT_W       = $clog2(FRAC_W);
    localparam int INT_MAG_MAX = (1 << (INT_W - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sign-magnitude pack; a zero magnitude never carries a sign.
    function automatic logic [INT_W-1:0] pack_int(input logic sign,
                                                  input logic [INT_W-2:0] mag);
        return {sign & (|mag), mag};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_to_int.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_int
// Brief    : Multi-cycle team-float to sign-magnitude int converter using a
//            1-bit/cycle denormalizing shifter with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module fp_to_int
    import fp_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [FLOAT_W-1:0] i_float,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [INT_W-1:0]   o_int,
    output logic               o_ovf,
    output logic               o_inexact,
    output logic               o_valid,
    input  logic               i_ready
);

    state_t              r_state;
    logic                r_sign;
    logic [FRAC_W-1:0]   r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sticky;
    logic [INT_W-1:0]    r_int;
    logic                r_ovf;
    logic                r_inexact;
    logic                r_valid;
    logic                r_ready;

    logic                w_sign;
    logic [EXP_W-1:0]    w_exp;
    logic [FRAC_W-1:0]   w_frac;
    logic                w_in_range;
    logic [EXP_W:0]      w_diff;
    logic [CNT_W-1:0]    w_cnt_init;
    logic [INT_W-2:0]    w_idle_mag;
    logic                w_idle_ovf;
    logic                w_idle_inexact;
    logic [FRAC_W-1:0]   w_sr_shift;
    logic                w_sticky_shift;

    always_comb begin
        w_sign         = i_float[FLOAT_W-1];
        w_exp          = i_float[FLOAT_W-2 -: EXP_W];
        w_frac         = i_float[FRAC_W-1:0];
        w_in_range     = (w_exp != '0) && (w_exp <= EXP_W'(INT_W - 1));
        w_diff         = (EXP_W+1)'(FRAC_W) - {1'b0, w_exp};
        w_cnt_init     = w_diff[CNT_W-1:0];
        w_sr_shift     = r_sr >> 1;
        w_sticky_shift = r_sticky | r_sr[0];
        // Out-of-range exponents resolve without shifting: zero or saturate.
        w_idle_mag     = '0;
        w_idle_ovf     = 1'b0;
        w_idle_inexact = 1'b0;
        if (w_exp == '0) begin
            w_idle_inexact = |w_frac;
        end else begin
            w_idle_mag = (INT_W-1)'(INT_MAG_MAX);
            w_idle_ovf = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_sticky  <= 1'b0;
            r_int     <= '0;
            r_ovf     <= 1'b0;
            r_inexact <= 1'b0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_sign   <= w_sign;
                        r_sr     <= w_frac;
                        r_sticky <= 1'b0;
                        r_ready  <= 1'b0;
                        if (w_in_range) begin
                            r_cnt   <= w_cnt_init;
                            r_state <= SHIFT;
                        end else begin
                            r_int     <= pack_int(w_sign, w_idle_mag);
                            r_ovf     <= w_idle_ovf;
                            r_inexact <= w_idle_inexact;
                            r_valid   <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_sr     <= w_sr_shift;
                    r_sticky <= w_sticky_shift;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_int     <= pack_int(r_sign, w_sr_shift[INT_W-2:0]);
                        r_ovf     <= 1'b0;
                        r_inexact <= w_sticky_shift;
                        r_valid   <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_int     = r_int;
    assign o_ovf     = r_ovf;
    assign o_inexact = r_inexact;
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_to_int
// Brief    : Self-checking bench for fp_to_int: vector table, random floats
//            against an arithmetic model, round trip, backpressure, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_to_int;

    logic        clk;
    logic        rst_n;
    logic [12:0] i_float;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_int;
    logic        o_ovf;
    logic        o_inexact;
    logic        o_valid;
    logic        i_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [12:0] f;
        logic [7:0]  r;
        logic        ovf;
        logic        inex;
        int          lat;
    } vec_t;

    fp_to_int u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_float   (i_float),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_int     (o_int),
        .o_ovf     (o_ovf),
        .o_inexact (o_inexact),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Value = 0.frac * 2^exp; the integer part is the magnitude, the fraction is lost.
    function automatic vec_t model(input logic [12:0] f);
        vec_t v;
        int   e;
        int   fr;
        int   sc;
        int   mag;
        e  = int'(f[11:8]);
        fr = int'(f[7:0]);
        sc = fr * (1 << e);
        v.f = f;
        if (e >= 8) begin
            mag    = 127;
            v.ovf  = 1'b1;
            v.inex = 1'b0;
        end else begin
            mag    = sc / 256;
            v.ovf  = 1'b0;
            v.inex = (sc % 256) != 0;
        end
        v.r   = {f[12] && (mag != 0), mag[6:0]};
        v.lat = (e >= 1 && e <= 7) ? (9 - e) : 1;
        return v;
    endfunction

    task automatic run(input logic [12:0] f, output vec_t got);
        int lat;
        @(negedge clk);
        chk("ready_before_accept", int'(o_ready), 1);
        i_float = f;
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        got.f    = f;
        got.r    = o_int;
        got.ovf  = o_ovf;
        got.inex = o_inexact;
        got.lat  = lat;
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t got, input vec_t exp);
        chk({tag, "_int"}, int'(got.r), int'(exp.r));
        chk({tag, "_ovf"}, int'(got.ovf), int'(exp.ovf));
        chk({tag, "_inexact"}, int'(got.inex), int'(exp.inex));
        chk({tag, "_latency"}, got.lat, exp.lat);
    endtask

    initial begin
        vec_t        tbl[6];
        vec_t        got;
        vec_t        exp_v;
        logic [12:0] f;
        logic [7:0]  held_int;
        logic        held_ovf;
        logic        held_inex;
        int          lat;

        tbl[0] = '{13'h07FE, 8'h7F, 1'b0, 1'b0, 2};
        tbl[1] = '{13'h13A0, 8'h85, 1'b0, 1'b0, 6};
        tbl[2] = '{13'h01C0, 8'h01, 1'b0, 1'b1, 8};
        tbl[3] = '{13'h1000, 8'h00, 1'b0, 1'b0, 1};
        tbl[4] = '{13'h0980, 8'h7F, 1'b1, 1'b0, 1};
        tbl[5] = '{13'h1980, 8'hFF, 1'b1, 1'b0, 1};

        rst_n   = 1'b0;
        i_float = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", int'(o_ready), 1);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_int", int'(o_int), 0);
        chk("reset_ovf", int'(o_ovf), 0);
        chk("reset_inexact", int'(o_inexact), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].f, got);
            compare("table", got, tbl[i]);
        end

        for (int i = 0; i < 150; i++) begin
            f = 13'($urandom_range(0, 8191));
            run(f, got);
            compare("random", got, model(f));
        end

        // Round trip: normalized encoding of every int must come back unchanged.
        for (int i = 0; i < 256; i++) begin
            int mag;
            int e;
            mag = i % 128;
            e   = 0;
            while ((1 << e) <= mag) e++;
            f = {(i >= 128) ? 1'b1 : 1'b0, 4'(e), 8'(mag << (8 - e))};
            if (mag == 0) f[7:0] = 8'h00;
            run(f, got);
            chk("roundtrip_int", int'(got.r), (mag == 0) ? 0 : i);
            chk("roundtrip_inexact", int'(got.inex), 0);
        end

        // Backpressure: result held in DONE, concurrent request not taken.
        @(negedge clk);
        i_float = 13'h07FE;
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp_latency", lat, 2);
        held_int  = o_int;
        held_ovf  = o_ovf;
        held_inex = o_inexact;
        chk("bp_int", int'(held_int), 8'h7F);
        @(negedge clk);
        i_float = 13'h0980;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(o_valid), 1);
            chk("bp_hold_ready", int'(o_ready), 0);
            chk("bp_hold_int", int'(o_int), int'(held_int));
            chk("bp_hold_ovf", int'(o_ovf), int'(held_ovf));
            chk("bp_hold_inexact", int'(o_inexact), int'(held_inex));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        chk("bp_release_valid", int'(o_valid), 0);
        chk("bp_release_ready", int'(o_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_not_consumed_valid", int'(o_valid), 0);
            chk("bp_not_consumed_ready", int'(o_ready), 1);
        end

        // Asynchronous reset while shifting 13'h01C0.
        @(negedge clk);
        i_float = 13'h01C0;
        i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_busy", int'(o_ready), 0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_valid", int'(o_valid), 0);
        chk("rst_mid_ready", int'(o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(13'h07FE, got);
        exp_v = '{13'h07FE, 8'h7F, 1'b0, 1'b0, 2};
        compare("after_reset", got, exp_v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
